// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tts_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;

    // Bit position in the truth-table word for a given input vector
    // (vector 000 lands in bit 7, vector 111 in bit 0).
    function automatic logic [VEC_W-1:0] vec_bit(input logic [VEC_W-1:0] idx);
        return VEC_W'(NUM_VECTORS - 1) - idx;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host-side control/result bundle of the truth-table sweeper.
interface truth_table_sweeper_if;
    import tts_pkg::*;

    logic                   start;
    logic                   abort;
    logic [NUM_VECTORS-1:0] expected;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] measured;
    logic                   pass;
    logic [NUM_VECTORS-1:0] mismatch;

    modport master (
        output start, abort, expected,
        input  busy, done, measured, pass, mismatch
    );

    modport slave (
        input  start, abort, expected,
        output busy, done, measured, pass, mismatch
    );

endinterface

// File: rtl/tts_settle_timer.sv
// Loadable down-counter; expired is high on the last cycle of a loaded count.
module tts_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count <= CNT_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Applies all 8 vectors to a 3-input gate, assembles its truth table and
// compares it against the expected code latched at start.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  host,
    output logic [VEC_W-1:0]      gate_in,
    input  logic                  gate_out
);

    state_t                 state;
    logic [VEC_W-1:0]       idx;
    logic [NUM_VECTORS-1:0] exp_q;
    logic [NUM_VECTORS-1:0] meas_upd;
    logic                   settle_load;
    logic                   settle_expired;

    assign settle_load = (state == APPLY);

    tts_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (settle_load),
        .value   (CNT_W'(SETTLE_CYCLES)),
        .expired (settle_expired)
    );

    // Measured word with the current vector's sample merged in.
    always_comb begin
        meas_upd                = host.measured;
        meas_upd[vec_bit(idx)]  = gate_out;
    end

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            exp_q         <= '0;
            gate_in       <= '0;
            host.busy     <= 1'b0;
            host.done     <= 1'b0;
            host.measured <= '0;
            host.pass     <= 1'b0;
            host.mismatch <= '0;
        end else begin
            host.done <= 1'b0;
            if (host.abort && state != IDLE && state != DONE) begin
                state     <= IDLE;
                gate_in   <= '0;
                host.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (host.start) begin
                            exp_q         <= host.expected;
                            host.measured <= '0;
                            idx           <= '0;
                            host.busy     <= 1'b1;
                            state         <= APPLY;
                        end
                    end
                    APPLY: begin
                        gate_in <= idx;
                        state   <= (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
                    end
                    SETTLE: begin
                        if (settle_expired) begin
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        host.measured <= meas_upd;
                        if (idx == VEC_W'(NUM_VECTORS - 1)) begin
                            // Result is registered on entry to DONE so that
                            // pass/mismatch are already valid while done is high.
                            host.done     <= 1'b1;
                            host.pass     <= (meas_upd == exp_q);
                            host.mismatch <= meas_upd ^ exp_q;
                            state         <= DONE;
                        end else begin
                            idx   <= idx + VEC_W'(1);
                            state <= APPLY;
                        end
                    end
                    DONE: begin
                        gate_in   <= '0;
                        host.busy <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 0)
// checked every cycle against a closed-form timing model.
module tb_truth_table_sweeper;
    import tts_pkg::*;

    localparam int S_A = 4;
    localparam int S_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] gate_code;

    truth_table_sweeper_if ifa ();
    truth_table_sweeper_if ifb ();

    logic [2:0] gin_a, gin_b;
    logic       gout_a, gout_b;

    function automatic logic gate_fn(input logic [7:0] code, input logic [2:0] v);
        logic [2:0] pos;
        pos = 3'd7 - v;
        return code[pos];
    endfunction

    assign gout_a = gate_fn(gate_code, gin_a);
    assign gout_b = gate_fn(gate_code, gin_b);

    truth_table_sweeper #(.SETTLE_CYCLES(S_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .host(ifa), .gate_in(gin_a), .gate_out(gout_a)
    );
    truth_table_sweeper #(.SETTLE_CYCLES(S_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .host(ifb), .gate_in(gin_b), .gate_out(gout_b)
    );

    // Per-instance views of stimulus and outputs.
    logic       start_v [2];
    logic       abort_v [2];
    logic [7:0] exp_v   [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic [7:0] meas_o  [2];
    logic [7:0] mis_o   [2];
    logic [2:0] gin_o   [2];

    assign ifa.start = start_v[0];
    assign ifa.abort = abort_v[0];
    assign ifa.expected = exp_v[0];
    assign ifb.start = start_v[1];
    assign ifb.abort = abort_v[1];
    assign ifb.expected = exp_v[1];
    assign busy_o[0] = ifa.busy;
    assign busy_o[1] = ifb.busy;
    assign done_o[0] = ifa.done;
    assign done_o[1] = ifb.done;
    assign pass_o[0] = ifa.pass;
    assign pass_o[1] = ifb.pass;
    assign meas_o[0] = ifa.measured;
    assign meas_o[1] = ifb.measured;
    assign mis_o[0] = ifa.mismatch;
    assign mis_o[1] = ifb.mismatch;
    assign gin_o[0] = gin_a;
    assign gin_o[1] = gin_b;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s dut%0d t=%0t got %0h want %0h", nm, i, $time, got, want);
    endtask

    // ---------------- behavioural model ----------------
    // Relative cycle c counts from the cycle after start was accepted (c=1).
    // A sweep is 8 vectors of (s+2) cycles; done sits at c = 8*(s+2)+1.
    int         s_cfg [2] = '{S_A, S_B};
    bit         m_ok = 1'b0;
    bit         m_act [2];
    int         m_c   [2];
    logic [7:0] m_exp [2];
    logic [7:0] m_code[2];
    logic [7:0] m_meas[2];
    logic       m_pass[2];
    logic [7:0] m_mis [2];

    function automatic int done_cyc(input int s);
        return 8 * (s + 2) + 1;
    endfunction

    // Truth-table bits gathered by relative cycle c: one more MSB-first bit
    // becomes visible every (s+2) cycles.
    function automatic logic [7:0] partial(input logic [7:0] code, input int s, input int c);
        int n;
        logic [7:0] mask;
        n = (c - 1) / (s + 2);
        if (n > 8) n = 8;
        if (n < 0) n = 0;
        mask = ~(8'hFF >> n);
        return code & mask;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_c[i] = 0;
                m_meas[i] = 8'h00; m_pass[i] = 1'b0; m_mis[i] = 8'h00;
            end
        end else if (m_ok) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_act[i]) begin
                    if (start_v[i]) begin
                        m_act[i] = 1'b1; m_c[i] = 1;
                        m_exp[i] = exp_v[i]; m_code[i] = gate_code;
                    end
                end else if (m_c[i] == done_cyc(s_cfg[i])) begin
                    m_act[i]  = 1'b0;
                    m_meas[i] = m_code[i];
                    m_pass[i] = (m_code[i] == m_exp[i]);
                    m_mis[i]  = m_code[i] ^ m_exp[i];
                end else if (abort_v[i]) begin
                    m_act[i]  = 1'b0;
                    m_meas[i] = partial(m_code[i], s_cfg[i], m_c[i]);
                end else begin
                    m_c[i]++;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            for (int i = 0; i < 2; i++) begin
                int s, c, d, e_gin;
                logic e_busy, e_done, e_pass;
                logic [7:0] e_meas, e_mis;
                s = s_cfg[i];
                c = m_c[i];
                d = done_cyc(s);
                if (m_act[i]) begin
                    e_busy = 1'b1;
                    e_gin  = (c >= 2) ? (c - 2) / (s + 2) : 0;
                    e_done = (c == d);
                    e_meas = partial(m_code[i], s, c);
                    e_pass = (c == d) ? (m_code[i] == m_exp[i]) : m_pass[i];
                    e_mis  = (c == d) ? (m_code[i] ^ m_exp[i]) : m_mis[i];
                end else begin
                    e_busy = 1'b0; e_gin = 0; e_done = 1'b0;
                    e_meas = m_meas[i]; e_pass = m_pass[i]; e_mis = m_mis[i];
                end
                chk("busy", i, 32'(busy_o[i]), 32'(e_busy));
                chk("gate_in", i, 32'(gin_o[i]), 32'(e_gin));
                chk("done", i, 32'(done_o[i]), 32'(e_done));
                chk("measured", i, 32'(meas_o[i]), 32'(e_meas));
                chk("pass", i, 32'(pass_o[i]), 32'(e_pass));
                chk("mismatch", i, 32'(mis_o[i]), 32'(e_mis));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic start_sweep(input int i, input logic [7:0] e);
        @(negedge clk);
        start_v[i] = 1'b1;
        exp_v[i]   = e;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 1;
        while (done_o[i] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", i, 32'(done_o[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        bit seen;
        rst_n = 1'b0;
        gate_code = 8'hD1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; exp_v[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_measured", 0, 32'(meas_o[0]), 32'h00);

        // Gate 0xD1, matching expectation.
        start_sweep(0, 8'hD1);
        wait_done(0, lat);
        chk("latency_s4", 0, lat, 32'd49);
        chk("t1_measured", 0, 32'(meas_o[0]), 32'hD1);
        chk("t1_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("t1_mismatch", 0, 32'(mis_o[0]), 32'h00);

        // Expected 0xD3, abort held through DONE and into IDLE.
        start_sweep(0, 8'hD3);
        wait_done(0, lat);
        abort_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("t2_measured", 0, 32'(meas_o[0]), 32'hD1);
        chk("t2_pass", 0, 32'(pass_o[0]), 32'd0);
        chk("t2_mismatch", 0, 32'(mis_o[0]), 32'h02);

        // Zero settle time.
        start_sweep(1, 8'hD1);
        wait_done(1, lat);
        chk("latency_s0", 1, lat, 32'd17);
        chk("t3_measured", 1, 32'(meas_o[1]), 32'hD1);
        chk("t3_pass", 1, 32'(pass_o[1]), 32'd1);

        // Abort while vector 5 is applied.
        start_sweep(0, 8'hD1);
        k = 0;
        while (gin_o[0] !== 3'd5 && k < 200) begin @(negedge clk); k++; end
        chk("reach_vec5", 0, 32'(gin_o[0]), 32'd5);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("abort_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("abort_gate_in", 0, 32'(gin_o[0]), 32'd0);
        chk("abort_meas_hi", 0, 32'(meas_o[0][7:3]), 32'b11010);
        chk("abort_pass_kept", 0, 32'(pass_o[0]), 32'd0);
        chk("abort_mis_kept", 0, 32'(mis_o[0]), 32'h02);
        seen = 1'b0;
        repeat (60) begin @(negedge clk); if (done_o[0] === 1'b1) seen = 1'b1; end
        chk("abort_no_done", 0, 32'(seen), 32'd0);

        // Reset during vector 3 settle, then a fresh sweep.
        start_sweep(0, 8'hD1);
        k = 0;
        while (gin_o[0] !== 3'd3 && k < 200) begin @(negedge clk); k++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_mid_gate_in", 0, 32'(gin_o[0]), 32'd0);
        chk("rst_mid_measured", 0, 32'(meas_o[0]), 32'h00);
        chk("rst_mid_pass", 0, 32'(pass_o[0]), 32'd0);
        chk("rst_mid_mismatch", 0, 32'(mis_o[0]), 32'h00);
        start_sweep(0, 8'hD1);
        wait_done(0, lat);
        chk("latency_after_rst", 0, lat, 32'd49);
        chk("after_rst_pass", 0, 32'(pass_o[0]), 32'd1);

        // Restart attempt and expected change mid-sweep are ignored.
        @(negedge clk);
        gate_code = 8'h96;
        start_sweep(0, 8'h96);
        repeat (10) @(negedge clk);
        start_v[0] = 1'b1;
        exp_v[0]   = 8'h00;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, lat);
        chk("latency_no_restart", 0, lat, 32'd38);
        chk("t6_measured", 0, 32'(meas_o[0]), 32'h96);
        chk("t6_pass", 0, 32'(pass_o[0]), 32'd1);
        chk("t6_mismatch", 0, 32'(mis_o[0]), 32'h00);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that characterises one 3-input combinational logic gate (e.g. gate m0xD1) by applying all 8 input vectors in order.
- Waits a programmable settle time per vector, then samples the gate output and assembles an 8-bit truth-table word.
- Compares that word against an expected code and reports the result.
- Sits between a test/configuration host and any single-output, 3-input gate instance in the design.

Parameters:
- SETTLE_CYCLES, 4, clock cycles to wait after applying a vector before sampling; legal range 0..255.
- CNT_W, 8, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel a sweep in progress.
- expected  input  8  expected truth-table code; bit 7 is the output for input 000, bit 0 for input 111.
- gate_in  output  3  drives {in1,in2,in3} of the gate under test; gate_in[2] is in1.
- gate_out  input  1  output of the gate under test.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a sweep completes (not on abort).
- measured  output  8  captured truth table, same bit order as expected.
- pass  output  1  measured == latched expected; valid from done onward.
- mismatch  output  8  measured XOR latched expected; valid from done onward.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - gate_in, measured, mismatch = 0; busy, done, pass = 0.
  - Reset overrides start and abort, and takes effect mid-sweep.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - When start = 1, latch expected into exp_q, clear measured, set vector index idx = 0, go to APPLY.
- APPLY:
  - gate_in <= idx (registered).
  - If SETTLE_CYCLES > 0, load the settle counter and go to SETTLE; otherwise go to SAMPLE.
- SETTLE:
  - Hold gate_in and count down for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - Capture gate_out into measured[7-idx].
  - If idx == 7, go to DONE; otherwise idx <= idx+1 and go to APPLY.
- DONE (one cycle):
  - done = 1; pass and mismatch are computed from the final measured value; gate_in <= 0; then go to IDLE.
  - pass and mismatch hold until the next start or reset.
- Latency and timing:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - If start is sampled in cycle 0, done is high in cycle 8*(SETTLE_CYCLES+2)+1.
  - A new start is accepted in the cycle after done at the earliest.
- start while busy is ignored; expected changes after the start cycle have no effect.
- abort:
  - When busy and not in DONE: next state is IDLE, gate_in <= 0, no done pulse.
  - measured keeps its partial contents; pass and mismatch keep their previous values.
  - abort in IDLE is ignored; abort in DONE is ignored (done still pulses).
  - start and abort high together in IDLE: start wins.
- idx is 3 bits; it wraps by design, never exceeding 7 in SAMPLE.
- gate_out is assumed synchronous to clk; any synchroniser is outside this block.

Decomposition:
- Package tts_pkg:
  - state enum {IDLE, APPLY, SETTLE, SAMPLE, DONE}.
  - NUM_VECTORS = 8; VEC_W = 3.
  - Function vec_bit(idx) = 7-idx.
- Sub-module tts_settle_timer:
  - Loadable down-counter with parameter CNT_W.
  - Inputs: load, value. Output: expired.
  - Instantiated once in truth_table_sweeper.

Test Plan:
- Reset mid-sweep: start, then rst_n low during vector 3 SETTLE -> next cycle all outputs 0, state IDLE; a fresh start works normally.
- Gate m0xD1 (truth 1,1,0,1,0,0,0,1), expected = 0xD1, SETTLE_CYCLES = 4 -> done exactly 49 cycles after start; measured = 0xD1; pass = 1; mismatch = 0x00; gate_in sequence 0..7, each value held 6 cycles.
- Same gate, expected = 0xD3 -> measured = 0xD1, pass = 0, mismatch = 0x02.
- SETTLE_CYCLES = 0 -> done 17 cycles after start; measured = 0xD1.
- Abort asserted while gate_in = 5 -> busy low next cycle, no done pulse, gate_in = 0, measured[7:3] = 11010, previous pass/mismatch unchanged.
- start pulsed while busy, plus expected changed mid-sweep -> no restart; result compared against expected latched at original start.
